// File: rtl/adsr_env.sv
// ============================================================================
// adsr_env -- parametrised ADSR envelope generator for the synth voice path.
//
// Purpose:
//   Produces a registered envelope level (OUTVALUE) that climbs during
//   ATTACK, falls to the sustain level during DECAY, holds in SUSTAIN while
//   the gate (START) is high and falls to zero in RELEASE once it drops.
//   Each stage advances one level step every <stage interval>+1 cycles.
//
// Parameters:
//   OUT_W   envelope level width, MAX = 2**OUT_W - 1
//   INT_W   width of the stage intervals and of the tick counter
//   RETRIG  0: a gate rise restarts attack from 0; 1: legato, attack resumes
//           from the current level
//
// Optional build macro:
//   ADSR_ENV_HOLD_EN  adds H_INTERVAL and a HOLD stage (STAGE=5) that keeps
//                     MAX for H_INTERVAL+1 cycles between ATTACK and DECAY.
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   synchronous active-high reset
//   A_INTERVAL  in   attack cycles per step minus 1
//   D_INTERVAL  in   decay cycles per step minus 1
//   SUS_LVL     in   sustain level
//   R_INTERVAL  in   release cycles per step minus 1
//   H_INTERVAL  in   hold length minus 1 (ADSR_ENV_HOLD_EN only)
//   START       in   gate, high while the note is held
//   OUTVALUE    out  envelope level (registered)
//   RUNNING     out  high whenever the generator is not IDLE
//   STAGE       out  0 IDLE, 1 ATTACK, 2 DECAY, 3 SUSTAIN, 4 RELEASE, 5 HOLD
//   DONE        out  one-cycle pulse on RELEASE -> IDLE
// ============================================================================
module adsr_env #(
    parameter int OUT_W  = 7,
    parameter int INT_W  = 32,
    parameter int RETRIG = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [INT_W-1:0] A_INTERVAL,
    input  logic [INT_W-1:0] D_INTERVAL,
    input  logic [OUT_W-1:0] SUS_LVL,
    input  logic [INT_W-1:0] R_INTERVAL,
`ifdef ADSR_ENV_HOLD_EN
    input  logic [INT_W-1:0] H_INTERVAL,
`endif
    input  logic             START,
    output logic [OUT_W-1:0] OUTVALUE,
    output logic             RUNNING,
    output logic [2:0]       STAGE,
    output logic             DONE
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4,
        HOLD    = 3'd5
    } state_t;

    localparam logic [OUT_W-1:0] MAX     = '1;
    localparam logic [OUT_W-1:0] ONE_LVL = {{(OUT_W-1){1'b0}}, 1'b1};
    localparam logic [INT_W-1:0] ONE_CNT = {{(INT_W-1){1'b0}}, 1'b1};

`ifdef ADSR_ENV_HOLD_EN
    localparam state_t ATTACK_DONE = HOLD;
`else
    localparam state_t ATTACK_DONE = DECAY;
`endif

    state_t           state_q, state_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic [INT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             start_q;
    logic             armed_q;

    logic [INT_W-1:0] cur_int;
    logic             tick;
    logic             rise;
    logic [OUT_W-1:0] lvl_inc;
    logic [OUT_W-1:0] lvl_dec;

    // armed_q only rises once START has been seen low, so a gate that is
    // already high while reset is applied cannot fake a rising edge after
    // reset is released.
    assign rise    = START & ~start_q & armed_q;
    assign lvl_inc = out_q + ONE_LVL;
    assign lvl_dec = out_q - ONE_LVL;

    always_comb begin
        cur_int = '0;
        case (state_q)
            ATTACK:  cur_int = A_INTERVAL;
            DECAY:   cur_int = D_INTERVAL;
            RELEASE: cur_int = R_INTERVAL;
`ifdef ADSR_ENV_HOLD_EN
            HOLD:    cur_int = H_INTERVAL;
`endif
            default: cur_int = '0;
        endcase
    end

    // Intervals are read live, so ">=" (not "==") makes a lowered interval
    // tick on the very next edge instead of waiting for the counter to wrap.
    assign tick = (cnt_q >= cur_int);

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        cnt_d   = tick ? '0 : (cnt_q + ONE_CNT);
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = ATTACK;
                    if (RETRIG == 0) out_d = '0;
                end
            end

            ATTACK: begin
                if (!START) begin
                    state_d = RELEASE;
                end else if (out_q == MAX) begin
                    state_d = ATTACK_DONE;
                end else if (tick) begin
                    out_d = lvl_inc;
                    if (lvl_inc == MAX) state_d = ATTACK_DONE;
                end
            end

`ifdef ADSR_ENV_HOLD_EN
            HOLD: begin
                if (!START) begin
                    state_d = RELEASE;
                end else if (tick) begin
                    state_d = DECAY;
                end
            end
`endif

            DECAY: begin
                if (!START) begin
                    state_d = RELEASE;
                end else if (out_q <= SUS_LVL) begin
                    state_d = SUSTAIN;
                end else if (tick) begin
                    out_d = lvl_dec;
                    if (lvl_dec == SUS_LVL) state_d = SUSTAIN;
                end
            end

            SUSTAIN: begin
                if (!START) state_d = RELEASE;
            end

            RELEASE: begin
                if (rise) begin
                    state_d = ATTACK;
                    if (RETRIG == 0) out_d = '0;
                end else if (out_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (tick) begin
                    out_d = lvl_dec;
                    if (lvl_dec == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                out_d   = '0;
            end
        endcase

        // Every state entry starts the stage timing afresh.
        if (state_d != state_q) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            out_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            start_q <= 1'b0;
            armed_q <= ~START;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            start_q <= START;
            armed_q <= armed_q | ~START;
        end
    end

    assign OUTVALUE = out_q;
    assign RUNNING  = (state_q != IDLE);
    assign STAGE    = state_q;
    assign DONE     = done_q;

endmodule

// File: tb/tb_adsr_env.sv
module tb_adsr_env;

    localparam int OUT_W = 7;
    localparam int INT_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [INT_W-1:0] a_int, d_int, r_int, h_int;
    logic [OUT_W-1:0] sus;
    logic             start;

    logic [OUT_W-1:0] out0, out1;
    logic             run0, run1, done0, done1;
    logic [2:0]       stage0, stage1;

    int checks = 0;
    int errors = 0;
    int stepno = 0;

    typedef struct {
        string tag;
        int    sig;
        int    exp;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    adsr_env #(.OUT_W(OUT_W), .INT_W(INT_W), .RETRIG(0)) u0 (
        .clk(clk), .rst(rst),
        .A_INTERVAL(a_int), .D_INTERVAL(d_int), .SUS_LVL(sus), .R_INTERVAL(r_int),
`ifdef ADSR_ENV_HOLD_EN
        .H_INTERVAL(h_int),
`endif
        .START(start),
        .OUTVALUE(out0), .RUNNING(run0), .STAGE(stage0), .DONE(done0)
    );

    adsr_env #(.OUT_W(OUT_W), .INT_W(INT_W), .RETRIG(1)) u1 (
        .clk(clk), .rst(rst),
        .A_INTERVAL(a_int), .D_INTERVAL(d_int), .SUS_LVL(sus), .R_INTERVAL(r_int),
`ifdef ADSR_ENV_HOLD_EN
        .H_INTERVAL(h_int),
`endif
        .START(start),
        .OUTVALUE(out1), .RUNNING(run1), .STAGE(stage1), .DONE(done1)
    );

    function automatic logic [31:0] obs(input int sig);
        case (sig)
            0: return 32'(out0);
            1: return 32'(stage0);
            2: return 32'(run0);
            3: return 32'(done0);
            4: return 32'(out1);
            5: return 32'(stage1);
            6: return 32'(run1);
            default: return 32'(done1);
        endcase
    endfunction

    function automatic string sig_name(input int sig);
        case (sig)
            0: return "u0.OUTVALUE";
            1: return "u0.STAGE";
            2: return "u0.RUNNING";
            3: return "u0.DONE";
            4: return "u1.OUTVALUE";
            5: return "u1.STAGE";
            6: return "u1.RUNNING";
            default: return "u1.DONE";
        endcase
    endfunction

    task automatic push(input int sig, input int value);
        exp_t e;
        e.tag = $sformatf("s%0d_%s", stepno, sig_name(sig));
        e.sig = sig;
        e.exp = value;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        logic [31:0] o;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = obs(e.sig);
            checks++;
            assert (o === 32'(e.exp)) else begin
                errors++;
                $error("FAIL %s observed=%0d expected=%0d", e.tag, o, e.exp);
            end
        end
    endtask

    // Expected values are queued as the stimulus is applied, then popped and
    // compared once the DUTs have run n more clock edges. -1 = not checked.
    task automatic go(input int n, input int ov, input int st, input int dn,
                      input int ov1 = -1, input int st1 = -1);
        stepno++;
        if (ov >= 0) push(0, ov);
        if (st >= 0) begin
            push(1, st);
            push(2, (st != 0) ? 1 : 0);
        end
        if (dn >= 0) push(3, dn);
        if (ov1 >= 0) push(4, ov1);
        if (st1 >= 0) begin
            push(5, st1);
            push(6, (st1 != 0) ? 1 : 0);
        end
        repeat (n) @(posedge clk);
        #1;
        drain();
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a_int = 1;
        d_int = 1;
        r_int = 1;
        h_int = 9;
        sus   = 8;

        // 1: full envelope at interval 1, sustain 8
        go(2, 0, 0, 0, 0, 0);
        rst = 1'b0;
        go(1, 0, 0, 0, 0, 0);
        start = 1'b1;
        go(1, 0, 1, 0, 0, 1);
        go(253, 126, 1, 0);
        go(1, 127, 2, 0, 127, 2);
        go(237, 9, 2, 0);
        go(1, 8, 3, 0, 8, 3);
        go(5, 8, 3, 0);
        start = 1'b0;
        go(1, 8, 4, 0);
        go(15, 1, 4, 0);
        go(1, 0, 0, 1, 0, 0);
        go(1, 0, 0, 0);

        // 2: attack every cycle, then release from 40
        a_int = 0;
        start = 1'b1;
        go(1, 0, 1, 0);
        go(126, 126, 1, 0);
        go(1, 127, 2, 0);
        start = 1'b0;
        r_int = 0;
        go(1, 127, 4, 0);
        go(127, 0, 0, 1);
        r_int = 1;
        start = 1'b1;
        go(1, 0, 1, 0);
        go(40, 40, 1, 0, 40, 1);
        start = 1'b0;
        go(1, 40, 4, 0, 40, 4);
        go(2, 39, 4, 0);

        // 3: retrigger during release at level 60
        go(78, 0, 0, 1);
        start = 1'b1;
        go(1, 0, 1, 0);
        go(100, 100, 1, 0, 100, 1);
        start = 1'b0;
        go(1, 100, 4, 0);
        go(80, 60, 4, 0, 60, 4);
        start = 1'b1;
        go(1, 0, 1, 0, 60, 1);
        go(1, 1, 1, 0, 61, 1);
        go(10, 11, 1, 0, 71, 1);
        start = 1'b0;
        go(1, 11, 4, 0, 71, 4);
        go(150, 0, 0, 0, 0, 0);

        // 4: sustain at MAX, then sustain at 0
        sus   = 127;
        start = 1'b1;
        go(1, 0, 1, 0);
        go(127, 127, 2, 0);
        go(1, 127, 3, 0);
        sus = 5;
        go(3, 127, 3, 0);
        start = 1'b0;
        r_int = 0;
        go(1, 127, 4, 0);
        go(127, 0, 0, 1);
        sus   = 0;
        d_int = 0;
        start = 1'b1;
        go(1, 0, 1, 0);
        go(127, 127, 2, 0);
        go(127, 0, 3, 0);
        go(1, 0, 3, 0);
        start = 1'b0;
        go(1, 0, 4, 0);
        go(1, 0, 0, 1);
        go(1, 0, 0, 0);

        // 5: reset mid-decay with the gate still high, then a 1-cycle pulse
        sus   = 8;
        start = 1'b1;
        go(1, 0, 1, 0);
        go(127, 127, 2, 0);
        go(27, 100, 2, 0);
        rst = 1'b1;
        go(1, 0, 0, 0, 0, 0);
        rst = 1'b0;
        go(5, 0, 0, 0, 0, 0);
        start = 1'b0;
        go(1, 0, 0, 0);
        start = 1'b1;
        go(1, 0, 1, 0, 0, 1);
        start = 1'b0;
        go(1, 0, 4, 0, 0, 4);
        go(1, 0, 0, 1, 0, 0);
        go(1, 0, 0, 0);

`ifdef ADSR_ENV_HOLD_EN
        // 6: hold at MAX for H_INTERVAL+1 cycles
        h_int = 9;
        a_int = 0;
        start = 1'b1;
        go(1, 0, 1, 0);
        go(127, 127, 5, 0);
        go(9, 127, 5, 0);
        go(1, 127, 2, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adsr_env.md
Name: adsr_env

Overview:
- Parametrised successor to the single-channel 7-bit ADSR envelope generator.
- Widths for level and interval are generic. Adds a synchronous reset and a selectable retrigger mode (restart vs legato).
- Release can start from any stage. Adds a stage output and an end-of-envelope pulse.
- Drives amplitude/filter modulation in the synth voice path.

Parameters:
- OUT_W, 7, envelope level width; MAX = 2^OUT_W - 1.
- INT_W, 32, width of every stage interval input and of the tick counter.
- RETRIG, 0, 0 = rising START restarts attack from level 0; 1 = legato, attack resumes from the current level.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- A_INTERVAL  in  INT_W  attack: cycles per step minus 1.
- D_INTERVAL  in  INT_W  decay: cycles per step minus 1.
- SUS_LVL  in  OUT_W  sustain level.
- R_INTERVAL  in  INT_W  release: cycles per step minus 1.
- START  in  1  gate; high = note held.
- OUTVALUE  out  OUT_W  envelope level (registered).
- RUNNING  out  1  high whenever state != IDLE.
- STAGE  out  3  0 IDLE, 1 ATTACK, 2 DECAY, 3 SUSTAIN, 4 RELEASE, 5 HOLD.
- DONE  out  1  one-cycle pulse on the RELEASE->IDLE transition.

Behaviour:
- Reset (rst=1 at an edge), same cycle:
  - state IDLE, OUTVALUE 0, RUNNING 0, STAGE 0, DONE 0.
  - Tick counter 0, START edge register 0.
  - Overrides all else, including mid-envelope.
- START is registered (START_q). A rise is START=1 and START_q=0 at an edge. State is ATTACK after that same edge, so latency is 1 edge.
- Tick counter:
  - Cleared on every state entry.
  - In ATTACK/DECAY/RELEASE: if counter >= current stage interval, it is a tick and the counter clears; otherwise it increments.
  - A step therefore occurs every interval+1 cycles; interval 0 = a step every cycle.
  - Intervals are read live. Lowering an interval below the current count forces a tick on the next edge.
- Attack entry: RETRIG=0 loads OUTVALUE=0; RETRIG=1 keeps OUTVALUE.
- ATTACK:
  - Each tick does OUTVALUE+1.
  - The tick that reaches MAX also moves to DECAY (or HOLD if enabled).
  - Entering with OUTVALUE=MAX moves to DECAY on the next edge with no step.
- DECAY:
  - If OUTVALUE <= SUS_LVL, move to SUSTAIN at the next edge with no step and OUTVALUE unchanged.
  - Otherwise each tick does OUTVALUE-1; the tick reaching SUS_LVL also moves to SUSTAIN.
  - SUS_LVL=MAX: decay lasts 1 cycle.
- SUSTAIN: OUTVALUE is held. SUS_LVL changes while in SUSTAIN are ignored.
- START=0 in ATTACK/DECAY/SUSTAIN/HOLD moves to RELEASE at that edge, starting from the current OUTVALUE.
- RELEASE:
  - Each tick does OUTVALUE-1; the tick reaching 0 moves to IDLE with DONE=1 for 1 cycle.
  - Entering with OUTVALUE=0 moves to IDLE at the next edge, with DONE pulsed.
- A START rise in RELEASE or IDLE moves to ATTACK, governed by RETRIG.
- START held high continuously after reset produces no attack; a rise is required.
- A START rise and fall in the same sampled value is impossible. A 1-cycle START pulse gives ATTACK for 1 cycle, then RELEASE.
- Arithmetic never wraps: no increment past MAX, no decrement below 0.

Optional Feature:
- Macro ADSR_ENV_HOLD_EN.
- Defined:
  - Adds input H_INTERVAL (INT_W) and state HOLD (STAGE=5).
  - ATTACK reaching MAX enters HOLD, which holds MAX for H_INTERVAL+1 cycles and then enters DECAY.
  - START=0 during HOLD goes to RELEASE.
- Undefined: no H_INTERVAL port, STAGE never 5, ATTACK goes straight to DECAY.

Test Plan:
1. Defaults; A=D=R=1, SUS_LVL=8; reset then START rise → ATTACK 1 edge later, RUNNING=1; OUTVALUE=127 after 254 cycles in ATTACK; SUSTAIN at 8 after 238 more; START=0 → OUTVALUE 0 after 16 cycles, DONE one pulse, RUNNING=0, STAGE=0.
2. A=0, START held → OUTVALUE increments every cycle, 127 reached 127 cycles after ATTACK entry; START dropped at OUTVALUE=40 → RELEASE from 40, no jump.
3. RETRIG=0 vs 1; START rise during RELEASE at OUTVALUE=60 → RETRIG=0 drops to 0 then climbs; RETRIG=1 climbs from 60.
4. SUS_LVL=127 → DECAY lasts 1 cycle, SUSTAIN at 127; SUS_LVL=0 → release from SUSTAIN enters IDLE at next edge, DONE pulses.
5. rst asserted mid-DECAY at OUTVALUE=100 → next edge OUTVALUE=0, STAGE=0, RUNNING=0, DONE=0; START already high does not retrigger without a new rise.
6. ADSR_ENV_HOLD_EN defined, H_INTERVAL=9, A=0 → OUTVALUE stays 127 with STAGE=5 for exactly 10 cycles, then STAGE=2.
